// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES key schedule for 128/192/256-bit keys.
// Generates one 32-bit schedule word per clock into a 4*(MAX_NK+7)-word store,
// then serves 128-bit round keys by index with a one-cycle read latency.
// Optional feature macro: KEYEXP_INV_MIX_EN (InvMixColumns on inner round keys
// when rk_inv is set, giving the equivalent-inverse-cipher key form).
module key_expansion_seq #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_idx,
  input  logic         rk_inv,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic         err,
  output logic [127:0] rk_data,
  output logic         rk_valid
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(DEPTH);

  // AES S-box, byte x lives at bits [(255-x)*8 +: 8]
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t          state_reg, state_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            ready_reg, ready_next;
  logic            err_reg, err_next;
  logic [3:0]      nk_reg, nr_reg;
  logic [AW-1:0]   i_reg;
  logic [2:0]      mod_reg;
  logic [7:0]      rcon_reg;
  logic [127:0]    rk_data_reg;
  logic            rk_valid_reg;

  logic [31:0]     store [DEPTH];

  logic [3:0]      nk_sel, nr_sel;
  logic            len_ok, idle_like, load, reject, last_word;
  logic [AW-1:0]   t_last, idx_prev, idx_back;
  logic [31:0]     w_prev, w_back, sub_in, sub_out, temp, w_new;

  logic [AW-1:0]   rd_base;
  logic            rd_hit;
  logic [127:0]    raw_key, rd_word;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign ready    = ready_reg;
  assign err      = err_reg;
  assign rk_data  = rk_data_reg;
  assign rk_valid = rk_valid_reg;

  // Mode decode: Nk = 4 + 2*key_len, Nr = Nk + 6; key_len 3 decodes to 10 and is rejected
  assign nk_sel    = 4'd4 + {1'b0, key_len, 1'b0};
  assign nr_sel    = nk_sel + 4'd6;
  assign len_ok    = (key_len != 2'd3) && (nk_sel <= 4'(MAX_NK));
  assign idle_like = (state_reg == IDLE) || (state_reg == DONE);
  assign load      = idle_like && start && len_ok;
  assign reject    = idle_like && start && !len_ok;
  assign t_last    = AW'({nr_reg, 2'b11});
  assign last_word = (state_reg == EXPAND) && (i_reg == t_last);

  // Word generator: w[i] = w[i-Nk] ^ temp, sharing a single SubWord unit
  assign idx_prev = i_reg - AW'(1);
  assign idx_back = i_reg - AW'(nk_reg);
  assign w_prev   = store[idx_prev];
  assign w_back   = store[idx_back];
  assign sub_in   = (mod_reg == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_out[8*gi +: 8] = sub_byte(sub_in[8*gi +: 8]);
    end
  endgenerate

  // Select the temp transform according to the position within the Nk-word period
  always_comb begin
    temp = w_prev;
    if (mod_reg == 3'd0)
      temp = sub_out ^ {rcon_reg, 24'h0};
    else if ((nk_reg == 4'd8) && (mod_reg == 3'd4))
      temp = sub_out;
  end

  assign w_new = w_back ^ temp;

  // Next-state and registered-output decode for the IDLE/EXPAND/DONE controller
  always_comb begin
    state_next = state_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;
    err_next   = reject;
    case (state_reg)
      IDLE, DONE: if (load) state_next = EXPAND;
      EXPAND:     if (last_word) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (load)
      ready_next = 1'b0;
    else if (last_word) begin
      ready_next = 1'b1;
      done_next  = 1'b1;
    end
    busy_next = (state_next == EXPAND);
  end

  // Controller state and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      ready_reg <= ready_next;
      err_reg   <= err_next;
    end
  end

  // Expansion counters: word index, wrapping i mod Nk counter and rcon
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nk_reg   <= 4'd0;
      nr_reg   <= 4'd0;
      i_reg    <= '0;
      mod_reg  <= 3'd0;
      rcon_reg <= 8'h00;
    end else if (load) begin
      nk_reg   <= nk_sel;
      nr_reg   <= nr_sel;
      i_reg    <= AW'(nk_sel);
      mod_reg  <= 3'd0;
      rcon_reg <= 8'h01;
    end else if (state_reg == EXPAND) begin
      i_reg   <= i_reg + AW'(1);
      mod_reg <= ({1'b0, mod_reg} == nk_reg - 4'd1) ? 3'd0 : mod_reg + 3'd1;
      if (mod_reg == 3'd0)
        rcon_reg <= xtime(rcon_reg);
    end
  end

  // Schedule store: key words copied on start, one generated word per EXPAND cycle
  always_ff @(posedge clk) begin
    for (int j = 0; j < MAX_NK; j++) begin
      if (load && (j < int'(nk_sel)))
        store[j] <= key[255 - 32*j -: 32];
    end
    if (state_reg == EXPAND)
      store[i_reg] <= w_new;
  end

  // Round-key fetch
  assign rd_base = AW'({rk_idx, 2'b00});
  assign rd_hit  = rk_rd_en && ready_reg && (rk_idx <= nr_reg);
  assign raw_key = {store[rd_base], store[rd_base + AW'(1)],
                    store[rd_base + AW'(2)], store[rd_base + AW'(3)]};

`ifdef KEYEXP_INV_MIX_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] a2 [4];
    logic [7:0] a4 [4];
    logic [7:0] a8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31 - 8*k -: 8];
      a2[k] = xtime(a[k]);
      a4[k] = xtime(a2[k]);
      a8[k] = xtime(a4[k]);
      m9[k] = a8[k] ^ a[k];
      mb[k] = a8[k] ^ a2[k] ^ a[k];
      md[k] = a8[k] ^ a4[k] ^ a[k];
      me[k] = a8[k] ^ a4[k] ^ a2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [127:0] inv_key;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
      assign inv_key[32*gi +: 32] = inv_mix_col(raw_key[32*gi +: 32]);
    end
  endgenerate

  // Inner round keys take the equivalent-inverse form; first and last stay raw
  assign rd_word = (rk_inv && (rk_idx != 4'd0) && (rk_idx != nr_reg)) ? inv_key : raw_key;
`else
  logic unused_rk_inv;
  assign unused_rk_inv = rk_inv;
  assign rd_word       = raw_key;
`endif

  // Read port register: one-cycle latency, zero on a missed read, hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data_reg  <= 128'h0;
      rk_valid_reg <= 1'b0;
    end else if (rk_rd_en) begin
      rk_data_reg  <= rd_hit ? rd_word : 128'h0;
      rk_valid_reg <= rd_hit;
    end else begin
      rk_valid_reg <= 1'b0;
    end
  end

endmodule
